// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM state encoding and datapath widths for the dual-MAC sequencer
package mac_pkg;
   localparam int ACC_W = 16;
   localparam int OP_W  = 8;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mac_fpga.sv
// mac_fpga: dual signed product add, sum_out = cSumin + a0*b0 + a1*b1 wrapped to ACC_W
//   a0,a1,b0,b1 : signed OP_W operands
//   cSumin      : signed ACC_W running sum in
//   prod0,prod1 : the two full-width signed products (exported for exact-sum checks)
//   sum_out     : wrapped ACC_W sum
module mac_fpga
   import mac_pkg::*;
(
   input  logic signed [OP_W-1:0]   a0,
   input  logic signed [OP_W-1:0]   a1,
   input  logic signed [OP_W-1:0]   b0,
   input  logic signed [OP_W-1:0]   b1,
   input  logic signed [ACC_W-1:0]  cSumin,
   output logic signed [2*OP_W-1:0] prod0,
   output logic signed [2*OP_W-1:0] prod1,
   output logic signed [ACC_W-1:0]  sum_out
);
   assign prod0   = a0 * b0;
   assign prod1   = a1 * b1;
   assign sum_out = cSumin + ACC_W'(prod0) + ACC_W'(prod1);
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a len-beat dual-MAC job into a 16-bit accumulator with sticky overflow
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, len, cinit : job request, beat count, initial accumulator (sampled in IDLE)
//   abort             : cancels a job in RUN or DONE
//   in_valid/in_ready : operand beat handshake for a0,b0,a1,b1
//   out_valid/out_ready, result, ovf : result handshake with sticky overflow
//   busy              : high whenever not IDLE
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int LEN_W = 8
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [LEN_W-1:0]        len,
   input  logic signed [ACC_W-1:0] cinit,
   input  logic                    abort,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [OP_W-1:0]  a0,
   input  logic signed [OP_W-1:0]  a1,
   input  logic signed [OP_W-1:0]  b0,
   input  logic signed [OP_W-1:0]  b1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] result,
   output logic                    ovf,
   output logic                    busy
);
   localparam logic signed [ACC_W+1:0] MAX_V = (ACC_W+2)'(2**(ACC_W-1) - 1);
   localparam logic signed [ACC_W+1:0] MIN_V = -(ACC_W+2)'(2**(ACC_W-1));
   state_t                    state;
   logic signed [ACC_W-1:0]   acc;
   logic [LEN_W-1:0]          cnt;
   logic signed [2*OP_W-1:0]  prod0, prod1;
   logic signed [ACC_W-1:0]   mac_sum;
   logic signed [ACC_W+1:0]   exact;
   logic                      ov;
   mac_fpga u_mac (
      .a0      (a0),
      .a1      (a1),
      .b0      (b0),
      .b1      (b1),
      .cSumin  (acc),
      .prod0   (prod0),
      .prod1   (prod1),
      .sum_out (mac_sum)
   );
   // Two extra bits hold the exact sum of a 16-bit acc and two 16-bit products.
   assign exact  = (ACC_W+2)'(acc) + (ACC_W+2)'(prod0) + (ACC_W+2)'(prod1);
   assign ov     = (exact > MAX_V) || (exact < MIN_V);
   assign result = acc;
   // in_ready, out_valid and busy are registered alongside the state so no
   // output depends combinationally on any input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start && !abort) begin
               acc  <= cinit;
               ovf  <= 1'b0;
               cnt  <= len;
               busy <= 1'b1;
               if (len != '0) begin
                  state    <= RUN;
                  in_ready <= 1'b1;
               end else begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            RUN: if (abort) begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end else if (in_valid) begin
               acc <= mac_sum;
               ovf <= ovf | ov;
               cnt <= cnt - 1'b1;
               if (cnt == LEN_W'(1)) begin
                  state     <= DONE;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (abort || out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
